// File: rtl/change_dispenser_if.sv
// change_dispenser_if: refund request, balance input and coin-ejector handshake of change_dispenser.
interface change_dispenser_if;
  logic       refund;
  logic [7:0] left;
  logic       overflow;
  logic       coin_ack;
  logic [2:0] coin_out;
  logic       coin_valid;
  logic       busy;
  logic       done;
  logic [7:0] remain;
  logic       fault;
`ifdef COIN_COUNT_EN
  logic [3:0] coin_cnt;
`endif
  modport master (
    output refund, left, overflow, coin_ack,
    input  coin_out, coin_valid, busy, done, remain, fault
`ifdef COIN_COUNT_EN
    , coin_cnt
`endif
  );
  modport slave (
    input  refund, left, overflow, coin_ack,
    output coin_out, coin_valid, busy, done, remain, fault
`ifdef COIN_COUNT_EN
    , coin_cnt
`endif
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout of a latched balance; COIN_COUNT_EN adds the coin_cnt output.
module change_dispenser #(
  parameter int BIG_VAL     = 10,
  parameter int MID_VAL     = 5,
  parameter int ACK_TIMEOUT = 15
) (
  input logic clk,
  input logic reset,
  change_dispenser_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SELECT, WAIT_ACK, DONE, FAULT} state_t;
  state_t     state;
  logic [7:0] timer;
  logic [7:0] coin_val;
  always_comb coin_val = bus.coin_out[2] ? 8'(BIG_VAL) : bus.coin_out[1] ? 8'(MID_VAL) : {7'd0, bus.coin_out[0]};
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      timer          <= '0;
      bus.coin_out   <= '0;
      bus.coin_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.remain     <= '0;
      bus.fault      <= 1'b0;
`ifdef COIN_COUNT_EN
      bus.coin_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.refund && !bus.overflow) begin
`ifdef COIN_COUNT_EN
            bus.coin_cnt <= '0;
`endif
            if (bus.left == 8'd0) state <= DONE;
            else begin
              bus.remain <= bus.left;
              bus.busy   <= 1'b1;
              state      <= SELECT;
            end
          end
        end
        SELECT: begin
          if (bus.remain == 8'd0) state <= DONE;
          else begin
            bus.coin_out   <= bus.remain >= 8'(BIG_VAL) ? 3'b100 : bus.remain >= 8'(MID_VAL) ? 3'b010 : 3'b001;
            bus.coin_valid <= 1'b1;
            timer          <= '0;
            state          <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (bus.coin_ack) begin
            // chosen coin never exceeds remain, so this cannot underflow
            bus.remain     <= bus.remain - coin_val;
            bus.coin_valid <= 1'b0;
            bus.coin_out   <= '0;
`ifdef COIN_COUNT_EN
            bus.coin_cnt   <= bus.coin_cnt == 4'hf ? bus.coin_cnt : bus.coin_cnt + 4'd1;
`endif
            state          <= SELECT;
          end else if (timer == 8'(ACK_TIMEOUT - 1)) begin
            bus.fault      <= 1'b1;
            bus.coin_valid <= 1'b0;
            bus.coin_out   <= '0;
            state          <= FAULT;
          end else timer <= timer + 8'd1;
        end
        DONE: begin
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          bus.remain <= '0;
          state      <= IDLE;
        end
        FAULT: begin
          bus.fault      <= 1'b1;
          bus.busy       <= 1'b1;
          bus.coin_valid <= 1'b0;
          bus.coin_out   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: randomized refunds scored against a greedy-change model; directed reset/timeout/refusal cases.
module tb_change_dispenser;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   ack_en = 1'b0;
  logic prev_cv = 1'b0;
  logic [2:0] cur_coin = '0;
  typedef struct {bit is_done; logic [2:0] coin; int rem; int cnt;} exp_t;
  exp_t q[$];
  change_dispenser_if bus ();
  change_dispenser dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int cnt_val();
`ifdef COIN_COUNT_EN
    return int'(bus.coin_cnt);
`else
    return 0;
`endif
  endfunction
  // model: greedy change expressed as division/modulo over the coin values
  task automatic push_refund(int l);
    int nb, nm, ns, r, n;
    exp_t e;
    nb = l / 10; nm = (l % 10) / 5; ns = l % 5; r = l; n = nb + nm + ns;
    for (int i = 0; i < nb; i++) begin e = '{0, 3'b100, r, 0}; q.push_back(e); r -= 10; end
    for (int i = 0; i < nm; i++) begin e = '{0, 3'b010, r, 0}; q.push_back(e); r -= 5; end
    for (int i = 0; i < ns; i++) begin e = '{0, 3'b001, r, 0}; q.push_back(e); r -= 1; end
`ifdef COIN_COUNT_EN
    e = '{1, 3'b000, 0, n > 15 ? 15 : n};
`else
    e = '{1, 3'b000, 0, 0};
`endif
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.coin_valid === 1'b1 && prev_cv !== 1'b1) begin
      if (q.size() == 0) chk("unexpected_coin", int'(bus.coin_out), 0);
      else begin
        e = q.pop_front();
        chk("coin_not_done", int'(e.is_done), 0);
        chk("coin_out", int'(bus.coin_out), int'(e.coin));
        chk("coin_remain", int'(bus.remain), e.rem);
        cur_coin = e.coin;
      end
    end else if (bus.coin_valid === 1'b1) chk("coin_hold", int'(bus.coin_out), int'(cur_coin));
    if (bus.done === 1'b1) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("done_expected", int'(e.is_done), 1);
        chk("done_remain", int'(bus.remain), 0);
        chk("done_busy", int'(bus.busy), 0);
`ifdef COIN_COUNT_EN
        chk("done_coin_cnt", cnt_val(), e.cnt);
`endif
      end
    end
    prev_cv = bus.coin_valid;
  end
  initial begin
    int d, h;
    bus.coin_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_en && bus.coin_valid) begin
        d = $urandom_range(0, 3);
        repeat (d) @(negedge clk);
        bus.coin_ack = 1'b1;
        h = $urandom_range(1, 2);
        repeat (h) @(negedge clk);
        bus.coin_ack = 1'b0;
      end
    end
  end
  task automatic do_refund(int l);
    int i;
    @(negedge clk);
    bus.left = 8'(l); bus.overflow = 1'b0; bus.refund = 1'b1;
    push_refund(l);
    @(negedge clk);
    bus.refund = 1'b0;
    chk("latency_cv_early", int'(bus.coin_valid), 0);
    chk("latency_busy", int'(bus.busy), int'(l != 0));
    @(negedge clk);
    chk("latency_cv", int'(bus.coin_valid), int'(l != 0));
    // re-pulse refund and scramble left while busy; both must be ignored
    for (i = 0; i < 400 && bus.done !== 1'b1; i++) begin
      bus.refund = bus.busy && ($urandom_range(0, 3) == 0);
      bus.left = 8'($urandom);
      @(negedge clk);
    end
    bus.refund = 1'b0;
    if (i >= 400) chk("refund_timeout", 0, 1);
  endtask
  initial begin
    int n;
    reset = 1'b0; bus.refund = 1'b1; bus.left = 8'd20; bus.overflow = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_coin_out", int'(bus.coin_out), 0);
    chk("rst_coin_valid", int'(bus.coin_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_remain", int'(bus.remain), 0);
    chk("rst_fault", int'(bus.fault), 0);
`ifdef COIN_COUNT_EN
    chk("rst_coin_cnt", cnt_val(), 0);
`endif
    reset = 1'b1; bus.refund = 1'b0;
    @(negedge clk);
    bus.overflow = 1'b1; bus.refund = 1'b1; bus.left = 8'd40;
    @(negedge clk);
    bus.refund = 1'b0; bus.overflow = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovf_busy", int'(bus.busy), 0);
    chk("ovf_cv", int'(bus.coin_valid), 0);
    chk("ovf_remain", int'(bus.remain), 0);
    ack_en = 1'b1;
    do_refund(17);
    do_refund(0);
    do_refund(25);
    repeat (20) do_refund($urandom_range(0, 255));
    do_refund(255);
    ack_en = 1'b0;
    repeat (4) @(negedge clk);
    // ejector never acknowledges
    bus.left = 8'd30; bus.refund = 1'b1;
    q.push_back('{0, 3'b100, 30, 0});
    @(negedge clk);
    bus.refund = 1'b0;
    for (int i = 0; i < 10 && !bus.coin_valid; i++) @(negedge clk);
    n = 0;
    while (bus.coin_valid && bus.coin_out == 3'b100 && n < 100) begin n++; @(negedge clk); end
    chk("to_hold_cycles", n, 15);
    chk("to_fault", int'(bus.fault), 1);
    chk("to_cv", int'(bus.coin_valid), 0);
    chk("to_coin_out", int'(bus.coin_out), 0);
    chk("to_remain", int'(bus.remain), 30);
    chk("to_busy", int'(bus.busy), 1);
    repeat (5) @(negedge clk);
    chk("to_fault_sticky", int'(bus.fault), 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("to_rst_fault", int'(bus.fault), 0);
    chk("to_rst_busy", int'(bus.busy), 0);
    // reset one cycle after the first ack
    @(negedge clk);
    bus.left = 8'd25; bus.refund = 1'b1;
    q.push_back('{0, 3'b100, 25, 0});
    @(negedge clk);
    bus.refund = 1'b0;
    for (int i = 0; i < 10 && !bus.coin_valid; i++) @(negedge clk);
    bus.coin_ack = 1'b1;
    @(negedge clk);
    bus.coin_ack = 1'b0; reset = 1'b0;
    chk("mid_remain_after_ack", int'(bus.remain), 15);
    @(negedge clk);
    reset = 1'b1;
    chk("mid_rst_remain", int'(bus.remain), 0);
    chk("mid_rst_cv", int'(bus.coin_valid), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    ack_en = 1'b1;
    do_refund(40);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of the vending coin/balance memory: consumes its 8-bit remaining-balance (`left`) and `overflow` outputs.
- On a refund request, latches the balance and pays it out greedily as physical coins, one coin per handshake with the coin-ejector mechanism.
- Reports progress (`remain`), completion (`done`) and ejector stall (`fault`).

Parameters:
- BIG_VAL, 10, value in balance units of the large coin (coin_out = 3'b100).
- MID_VAL, 5, value of the medium coin (coin_out = 3'b010); must be < BIG_VAL. The small coin (3'b001) is fixed at 1.
- ACK_TIMEOUT, 15, cycles allowed in WAIT_ACK without coin_ack before entering FAULT (1..255).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- refund  in  1  refund request, sampled in IDLE only.
- left  in  8  balance to return (from coin memory).
- overflow  in  1  coin-memory overflow flag; refund is refused while high.
- coin_ack  in  1  ejector accepted the presented coin.
- coin_out  out  3  one-hot coin being presented (100 big, 010 mid, 001 small), 000 when idle.
- coin_valid  out  1  coin_out is valid; held until acknowledged.
- busy  out  1  refund in progress (SELECT/WAIT_ACK).
- done  out  1  one-cycle pulse when the refund completes.
- remain  out  8  balance still to be paid.
- fault  out  1  ejector timeout; sticky until reset.

Behaviour:
- Reset: reset==0 at a posedge forces state IDLE and clears coin_out, coin_valid, busy, done, remain, fault and the timer. This applies from any state, including mid-dispense.
- States: IDLE, SELECT, WAIT_ACK, DONE, FAULT.
- IDLE, refund==0: stay in IDLE.
- IDLE, refund==1 && overflow==1: ignored, stay in IDLE, no output change.
- IDLE, refund==1 && overflow==0 && left==0: go to DONE; done pulses on the following cycle and no coin is issued.
- IDLE, refund==1 && overflow==0 && left!=0: remain<=left, busy<=1, go to SELECT.
- SELECT (1 cycle):
  - remain>=BIG_VAL: coin_out<=100.
  - else remain>=MID_VAL: coin_out<=010.
  - else remain>=1: coin_out<=001.
  - For any of the above: coin_valid<=1, timer<=0, go to WAIT_ACK.
  - remain==0: go to DONE.
- WAIT_ACK:
  - coin_out/coin_valid are held stable.
  - coin_ack==1 at a posedge: remain<=remain minus the coin value, coin_valid<=0, coin_out<=000, go to SELECT.
  - Otherwise timer increments. When timer reaches ACK_TIMEOUT-1 with no ack, go to FAULT.
- DONE: done<=1 for exactly one cycle, busy<=0, remain==0, return to IDLE.
- FAULT:
  - fault<=1, busy<=1, coin_valid<=0, coin_out<=000.
  - remain holds the unpaid balance, including the coin that was not acknowledged.
  - Exits only through reset.
- Latency:
  - refund sampled at edge N gives coin_valid high after edge N+1.
  - Minimum of 2 cycles per coin (SELECT plus one WAIT_ACK cycle acknowledged immediately).
- Arithmetic: subtraction is 8-bit unsigned and never underflows, because the coin chosen is always ≤ remain.
- Ignored inputs:
  - refund is ignored in every state except IDLE.
  - coin_ack is ignored outside WAIT_ACK.
  - Changes on left after the latch have no effect.

Optional Feature:
- COIN_COUNT_EN defined: adds an output port coin_cnt, 4 bits.
  - Cleared on reset and on each accepted refund.
  - Increments on every acknowledged coin and saturates at 15.
  - Holds its value after DONE/FAULT until the next refund or reset.
- COIN_COUNT_EN undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles with refund=1, left=20 -> all outputs 0, state IDLE, no coin_valid.
- Normal payout: left=17, refund pulse, coin_ack asserted 1 cycle after each coin_valid rise -> coins 100, 010, 001, 001 in order; remain 17→7→2→1→0; single done pulse; busy falls with done; coin_cnt=4 when COIN_COUNT_EN is defined.
- Zero balance: left=0, refund pulse -> done high for exactly 1 cycle one cycle after DONE entry, coin_valid never asserted, busy stays 0.
- Timeout: left=30, refund, coin_ack never asserted -> coin_out=100 held for 15 cycles, then fault=1, coin_valid=0, remain=30; fault persists until reset=0, which clears it.
- Refusal and ignores: overflow=1 with refund -> no response. During a left=25 payout, refund re-pulsed and left changed to 99 -> payout still 10, 10, 5; coin_ack outside WAIT_ACK causes no remain change.
- Reset mid-dispense: left=25, reset=0 one cycle after the first ack -> next edge remain=0, coin_valid=0, busy=0; a new refund after reset=1 proceeds normally.
